// File: rtl/fetch_if.sv
// fetch_if: BRAM read port, jump redirect and decode handshake of the fetch stage
interface fetch_if;
    logic        mem_oen_n;
    logic [15:0] mem_rdaddress;
    logic [15:0] mem_data;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    modport master (
        output mem_oen_n, mem_rdaddress, instr_valid, instr, instr_pc,
        input  mem_data, jump_en, jump_addr, instr_ready
    );
    modport slave (
        input  mem_oen_n, mem_rdaddress, instr_valid, instr, instr_pc,
        output mem_data, jump_en, jump_addr, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, BRAM read issue and 2-entry instruction buffer feeding decode
module fetch_unit #(
    parameter int                   ADDR_BITS = 12,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
    logic [ADDR_BITS-1:0] r_pc, r_pend_pc;
    logic                 r_pend, r_head;
    logic [1:0]           r_count;
    logic [ADDR_BITS-1:0] r_fpc [2];
    logic [15:0]          r_fword [2];
    logic                 w_valid, w_pop, w_push, w_issue, w_slot, w_unused;
    logic [2:0]           w_occ;

    // Handshake and issue decisions; a read may issue into a full pipeline only when a pop frees a slot
    always_comb begin
        w_valid = ~rst & (r_count != 2'd0);
        w_pop   = w_valid & bus.instr_ready & ~bus.jump_en;
        w_push  = r_pend & ~bus.jump_en;
        w_occ   = {1'b0, r_count} + {2'b0, r_pend};
        w_issue = ~rst & ~bus.jump_en & ((w_occ < 3'd2) | ((w_occ == 3'd2) & w_pop));
        w_slot  = r_head ^ r_count[0];
    end

    assign bus.mem_oen_n     = ~w_issue;
    assign bus.mem_rdaddress = 16'(r_pc);
    assign bus.instr_valid   = w_valid;
    assign bus.instr         = w_valid ? r_fword[r_head] : 16'h0;
    assign bus.instr_pc      = w_valid ? 16'(r_fpc[r_head]) : 16'h0;
    assign w_unused          = ^bus.jump_addr;

    // PC advances on each issue, jumps redirect it; pend marks a read whose data arrives next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_issue;
            if (bus.jump_en)
                r_pc <= bus.jump_addr[ADDR_BITS-1:0];
            else if (w_issue)
                r_pc <= r_pc + ADDR_BITS'(1);
        end
    end

    // Remember the address of the read in flight so the returning word can be tagged
    always_ff @(posedge clk) begin
        if (w_issue)
            r_pend_pc <= r_pc;
    end

    // Buffer occupancy and head pointer; a jump or reset empties the buffer
    always_ff @(posedge clk) begin
        if (rst | bus.jump_en) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
        end else begin
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop)
                r_head <= ~r_head;
        end
    end

    // Capture the returning word at the tail; with a full buffer and a pop, the tail is the slot being freed
    always_ff @(posedge clk) begin
        if (w_push & ~rst) begin
            r_fpc[w_slot]   <= r_pend_pc;
            r_fword[w_slot] <= bus.mem_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && !w_pop && r_count == 2'd2));
endmodule
